// File: rtl/fsm_arbiter_n.sv
// Two-state N-way request arbiter, fixed priority or round-robin.
// Define FSM_ARBITER_TIMEOUT_EN to add the hold limit and timeout mask.
module fsm_arbiter_n #(
    parameter int NUM_REQ  = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 8,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic [IW-1:0]        gnt_id_n;
    logic                 busy_n;
    logic [IW-1:0]        last_id, last_id_n;
    logic [NUM_REQ-1:0]   eligible;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [IW-1:0]        win;
    int                   base;
    int                   pos;

`ifdef FSM_ARBITER_TIMEOUT_EN
    logic [7:0]           hold_cnt, hold_n;
    logic [NUM_REQ-1:0]   mask, mask_n;
    logic                 timeout_n;

    assign eligible = req & ~mask;
`else
    assign eligible = req;
    assign timeout  = 1'b0;
`endif

    // Rotate so the search start sits at bit 0, then take the lowest set bit.
    always_comb begin
        found = 1'b0;
        pos   = 0;
        base  = 0;
        if (RR_MODE != 0) begin
            base = int'(last_id) + 1;
            if (base >= NUM_REQ) base = 0;
        end
        dbl = {eligible, eligible} >> base;
        rot = dbl[NUM_REQ-1:0];
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                pos   = base + j;
            end
        end
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        win = IW'(pos);
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        last_id_n = last_id;
`ifdef FSM_ARBITER_TIMEOUT_EN
        hold_n    = hold_cnt;
        mask_n    = mask & req;
        timeout_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n      = GRANT;
                    gnt_n        = '0;
                    gnt_n[win]   = 1'b1;
                    gnt_id_n     = win;
                    busy_n       = 1'b1;
                    last_id_n    = win;
`ifdef FSM_ARBITER_TIMEOUT_EN
                    hold_n       = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
`ifdef FSM_ARBITER_TIMEOUT_EN
                    hold_n  = 8'd0;
                end else if (hold_cnt == 8'(MAX_HOLD)) begin
                    state_n        = IDLE;
                    gnt_n          = '0;
                    busy_n         = 1'b0;
                    hold_n         = 8'd0;
                    timeout_n      = 1'b1;
                    mask_n[gnt_id] = 1'b1;
                end else begin
                    hold_n = hold_cnt + 8'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            last_id  <= IW'(NUM_REQ - 1);
`ifdef FSM_ARBITER_TIMEOUT_EN
            hold_cnt <= 8'd0;
            mask     <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            busy     <= busy_n;
            last_id  <= last_id_n;
`ifdef FSM_ARBITER_TIMEOUT_EN
            hold_cnt <= hold_n;
            mask     <= mask_n;
            timeout  <= timeout_n;
`endif
        end
    end

endmodule
